// File: rtl/dmem_responder.sv
// Data-memory responder: serves one load/store at a time on a word-wide single-port SRAM.
// Sub-word stores use read-modify-write because the SRAM has no byte write mask.
module dmem_responder #(
  parameter int unsigned DEPTH  = 816,
  parameter int unsigned ADDR_W = 10
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err
);

  localparam logic [3:0] MEM_NO_MEM = 4'd0;
  localparam logic [3:0] MEM_LB     = 4'd1;
  localparam logic [3:0] MEM_LH     = 4'd2;
  localparam logic [3:0] MEM_LW     = 4'd3;
  localparam logic [3:0] MEM_LBU    = 4'd4;
  localparam logic [3:0] MEM_LHU    = 4'd5;
  localparam logic [3:0] MEM_SB     = 4'd6;
  localparam logic [3:0] MEM_SH     = 4'd7;
  localparam logic [3:0] MEM_SW     = 4'd8;

  typedef enum logic [2:0] {
    StIdle, StLdRd, StLdCap, StStWr, StRmwRd, StRmwWr, StResp
  } state_e;

  state_e state_q, state_d;

  logic [3:0]        op_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic [1:0]        err_q;

  logic [1:0]        acc_err;
  logic              misaligned;
  logic [31:0]       ld_fmt;
  logic [31:0]       merged;
  logic [31:0]       lane_b;
  logic [31:0]       lane_h;
  logic [31:0]       mask;

  logic              sram_ceb;
  logic              sram_web;
  logic [ADDR_W-1:0] sram_a;
  logic [31:0]       sram_d;
  logic [31:0]       sram_q;
  logic [31:0]       mem_q [DEPTH];

  // Request checks, first failing check wins.
  always_comb begin
    unique case (req_op)
      MEM_LW, MEM_SW:          misaligned = req_addr[1:0] != 2'b00;
      MEM_LH, MEM_LHU, MEM_SH: misaligned = req_addr[0];
      default:                 misaligned = 1'b0;
    endcase
    acc_err = 2'b00;
    if (req_op > MEM_SW) begin
      acc_err = 2'b11;
    end else if (misaligned) begin
      acc_err = 2'b01;
    end else if (req_addr[31:ADDR_W+2] != '0 || 32'(req_addr[ADDR_W+1:2]) >= DEPTH) begin
      acc_err = 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (acc_err != 2'b00) begin
            state_d = StResp;
          end else begin
            case (req_op)
              MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU: state_d = StLdRd;
              MEM_SW:                                   state_d = StStWr;
              MEM_SB, MEM_SH:                           state_d = StRmwRd;
              default:                                  state_d = StResp;
            endcase
          end
        end
      end
      StLdRd:  state_d = StLdCap;
      StLdCap: state_d = StResp;
      StStWr:  state_d = StResp;
      StRmwRd: state_d = StRmwWr;
      StRmwWr: state_d = StResp;
      StResp:  if (resp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Lane extraction for loads and lane insertion for sub-word stores.
  always_comb begin
    lane_b = sram_q >> {addr_q[1:0], 3'b000};
    lane_h = sram_q >> {addr_q[1], 4'b0000};
    case (op_q)
      MEM_LB:  ld_fmt = {{24{lane_b[7]}}, lane_b[7:0]};
      MEM_LBU: ld_fmt = {24'h0, lane_b[7:0]};
      MEM_LH:  ld_fmt = {{16{lane_h[15]}}, lane_h[15:0]};
      MEM_LHU: ld_fmt = {16'h0, lane_h[15:0]};
      default: ld_fmt = sram_q;
    endcase
    if (op_q == MEM_SH) begin
      mask   = 32'h0000_ffff << {addr_q[1], 4'b0000};
      merged = (sram_q & ~mask) | ((32'(wdata_q[15:0]) << {addr_q[1], 4'b0000}) & mask);
    end else begin
      mask   = 32'h0000_00ff << {addr_q[1:0], 3'b000};
      merged = (sram_q & ~mask) | ((32'(wdata_q[7:0]) << {addr_q[1:0], 3'b000}) & mask);
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      op_q    <= MEM_NO_MEM;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 2'b00;
    end else begin
      if (state_q == StIdle && req_valid) begin
        op_q    <= req_op;
        addr_q  <= req_addr[ADDR_W+1:0];
        wdata_q <= req_wdata;
        rdata_q <= '0;
        err_q   <= acc_err;
      end
      if (state_q == StLdCap) begin
        rdata_q <= ld_fmt;
      end
      if (state_q == StResp && resp_ready) begin
        rdata_q <= '0;
        err_q   <= 2'b00;
      end
    end
  end

  always_comb begin
    req_ready  = state_q == StIdle;
    resp_valid = state_q == StResp;
    sram_ceb   = 1'b1;
    sram_web   = 1'b1;
    sram_d     = wdata_q;
    unique case (state_q)
      StLdRd:  sram_ceb = 1'b0;
      StStWr:  begin sram_ceb = 1'b0; sram_web = 1'b0; end
      StRmwRd: sram_ceb = 1'b0;
      StRmwWr: begin sram_ceb = 1'b0; sram_web = 1'b0; sram_d = merged; end
      default: ;
    endcase
    // Reset overrides the macro strobes so an interrupted RMW never writes.
    if (resetn) begin
      sram_ceb = 1'b1;
      sram_web = 1'b1;
    end
  end

  assign sram_a     = addr_q[ADDR_W+1:2];
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  // Behavioural stand-in for sram_1p_32x816: synchronous read, no byte mask.
  always_ff @(posedge clk) begin
    if (!sram_ceb) begin
      if (!sram_web) begin
        mem_q[sram_a] <= sram_d;
      end else begin
        sram_q <= mem_q[sram_a];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a word-array reference model.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 816;
  localparam logic [3:0] MEM_NO_MEM = 4'd0;
  localparam logic [3:0] MEM_LB     = 4'd1;
  localparam logic [3:0] MEM_LH     = 4'd2;
  localparam logic [3:0] MEM_LW     = 4'd3;
  localparam logic [3:0] MEM_LBU    = 4'd4;
  localparam logic [3:0] MEM_LHU    = 4'd5;
  localparam logic [3:0] MEM_SB     = 4'd6;
  localparam logic [3:0] MEM_SH     = 4'd7;
  localparam logic [3:0] MEM_SW     = 4'd8;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;

  int unsigned vecs = 0;
  int unsigned miscompares = 0;
  int unsigned ceb_lo = 0;
  int unsigned web_lo = 0;
  logic [31:0] model_mem [DEPTH];

  always #5 clk = ~clk;

  dmem_responder dut (
    .clk        (clk),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  // Count SRAM strobe cycles mid-cycle, away from the clock edge.
  always @(negedge clk) begin
    if (!dut.sram_ceb) ceb_lo++;
    if (!dut.sram_web) web_lo++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] exp_err(input logic [3:0] op, input logic [31:0] addr);
    if (op > MEM_SW) return 2'b11;
    if ((op == MEM_LW || op == MEM_SW) && addr % 4 != 0) return 2'b01;
    if ((op == MEM_LH || op == MEM_LHU || op == MEM_SH) && addr % 2 != 0) return 2'b01;
    if (addr >= DEPTH * 4) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit is_load(input logic [3:0] op);
    return op == MEM_LB || op == MEM_LH || op == MEM_LW || op == MEM_LBU || op == MEM_LHU;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [3:0] op, input logic [31:0] addr);
    logic [31:0] word;
    logic [31:0] b;
    logic [31:0] h;
    if (exp_err(op, addr) != 2'b00 || !is_load(op)) return 32'h0;
    word = model_mem[addr / 4];
    b = (word >> (8 * (addr % 4))) % 256;
    h = (word >> (8 * (addr % 4))) % 65536;
    case (op)
      MEM_LB:  return (b >= 128) ? b - 32'd256 : b;
      MEM_LBU: return b;
      MEM_LH:  return (h >= 32768) ? h - 32'd65536 : h;
      MEM_LHU: return h;
      default: return word;
    endcase
  endfunction

  task automatic model_store(input logic [3:0] op, input logic [31:0] addr,
                             input logic [31:0] wdata);
    logic [7:0] bytes [4];
    logic [31:0] word;
    int k;
    word = model_mem[addr / 4];
    for (int i = 0; i < 4; i++) bytes[i] = 8'((word >> (8 * i)) % 256);
    k = int'(addr % 4);
    if (op == MEM_SB) begin
      bytes[k] = wdata[7:0];
    end else if (op == MEM_SH) begin
      bytes[k]     = wdata[7:0];
      bytes[k + 1] = wdata[15:8];
    end
    word = {bytes[3], bytes[2], bytes[1], bytes[0]};
    if (op == MEM_SW) word = wdata;
    model_mem[addr / 4] = word;
  endtask

  task automatic do_req(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        input int hold);
    logic [1:0]  e;
    logic [31:0] r;
    int lat, got_lat, exp_ceb, exp_web;
    int unsigned c0, w0;
    e = exp_err(op, addr);
    r = exp_rdata(op, addr);
    lat = 1; exp_ceb = 0; exp_web = 0;
    if (e == 2'b00) begin
      if (is_load(op)) begin lat = 3; exp_ceb = 1; end
      else if (op == MEM_SW) begin lat = 2; exp_ceb = 1; exp_web = 1; end
      else if (op == MEM_SB || op == MEM_SH) begin lat = 3; exp_ceb = 2; exp_web = 1; end
    end
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
    c0 = ceb_lo; w0 = web_lo;
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = 4'($urandom); req_addr = $urandom; req_wdata = $urandom;
    got_lat = 1;
    while (!resp_valid && got_lat < 20) begin
      @(posedge clk); #1;
      got_lat++;
    end
    check("latency", 32'(got_lat), 32'(lat));
    check("req_ready_busy", 32'(req_ready), 32'd0);
    check("resp_err", 32'(resp_err), 32'(e));
    check("resp_rdata", resp_rdata, r);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(resp_valid), 32'd1);
      check("hold_rdata", resp_rdata, r);
      check("hold_err", 32'(resp_err), 32'(e));
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("post_valid", 32'(resp_valid), 32'd0);
    check("post_req_ready", 32'(req_ready), 32'd1);
    check("post_rdata", resp_rdata, 32'h0);
    check("post_err", 32'(resp_err), 32'd0);
    check("ceb_cycles", ceb_lo - c0, 32'(exp_ceb));
    check("web_cycles", web_lo - w0, 32'(exp_web));
    if (e == 2'b00) model_store(op, addr, wdata);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_resp_rdata"}, resp_rdata, 32'h0);
    check({tag, "_resp_err"}, 32'(resp_err), 32'd0);
  endtask

  // SB interrupted by reset in its write cycle must leave the word untouched.
  task automatic rmw_reset(input logic [31:0] addr, input logic [31:0] wdata);
    int unsigned w0;
    w0 = web_lo;
    req_valid = 1'b1; req_op = MEM_SB; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    resetn = 1'b0;
    check("rmw_reset_web", web_lo - w0, 32'd0);
    check_reset_outputs("rmw_reset");
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] addr;
    resetn = 1'b1; req_valid = 1'b0; req_op = MEM_NO_MEM; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    resetn = 1'b0;

    for (int i = 0; i < int'(DEPTH); i++) do_req(MEM_SW, 32'(i * 4), $urandom, 0);

    do_req(MEM_SW, 32'h10, 32'hDEAD_BEEF, 0);
    do_req(MEM_LW, 32'h10, 32'h0, 0);
    check("plan1_word", model_mem[4], 32'hDEAD_BEEF);
    do_req(MEM_SW, 32'h20, 32'h1122_3344, 0);
    do_req(MEM_SB, 32'h21, 32'h0000_00AA, 0);
    do_req(MEM_LW, 32'h20, 32'h0, 0);
    do_req(MEM_SH, 32'h22, 32'h0000_8001, 0);
    do_req(MEM_LW, 32'h20, 32'h0, 0);
    check("plan2_word", model_mem[8], 32'h8001_AA44);
    do_req(MEM_LB, 32'h21, 32'h0, 0);
    do_req(MEM_LBU, 32'h21, 32'h0, 0);
    do_req(MEM_LH, 32'h22, 32'h0, 0);
    do_req(MEM_LHU, 32'h22, 32'h0, 0);
    do_req(MEM_LW, 32'h13, 32'h0, 0);
    do_req(MEM_SW, 32'hCC0, 32'hFFFF_FFFF, 0);
    do_req(MEM_LW, 32'h0, 32'h0, 0);
    do_req(4'hF, 32'h0, 32'h0, 0);
    do_req(MEM_LW, 32'hCBC, 32'h0, 0);
    do_req(MEM_LB, 32'h1000, 32'h0, 0);
    do_req(MEM_LW, 32'h20, 32'h0, 5);
    do_req(MEM_NO_MEM, 32'h20, 32'h0, 0);
    rmw_reset(32'h21, 32'h55);
    do_req(MEM_LW, 32'h20, 32'h0, 0);
    check("plan6_word", model_mem[8], 32'h8001_AA44);

    for (int n = 0; n < 400; n++) begin
      op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      addr = 32'($urandom_range(0, DEPTH + 3)) * 4 + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) addr = addr | (32'h1 << $urandom_range(12, 31));
      do_req(op, addr, $urandom, int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
